// File: rtl/branch_pkg.sv
// branch_pkg: branch kinds, counter limits and shared helpers for the branch resolver.
package branch_pkg;
  typedef enum logic [2:0] {
    BT_NONE = 3'd0,
    BT_BEQ  = 3'd1,
    BT_BNE  = 3'd2,
    BT_BLEZ = 3'd3,
    BT_BGTZ = 3'd4,
    BT_BLTZ = 3'd5,
    BT_BGEZ = 3'd6
  } br_type_e;
  localparam logic [1:0] SAT_MAX = 2'b11;
  localparam logic [1:0] SAT_MIN = 2'b00;
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
    return up ? (cnt == SAT_MAX ? cnt : cnt + 2'd1) : (cnt == SAT_MIN ? cnt : cnt - 2'd1);
  endfunction
  // Encoding 7 is reserved and behaves like BT_NONE.
  function automatic logic is_branch(input logic [2:0] t);
    return t != BT_NONE && t != 3'd7;
  endfunction
endpackage

// File: rtl/branch_resolver_if.sv
// branch_resolver_if: IF/ID-stage signals exchanged between the pipeline and the resolver.
interface branch_resolver_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] if_pc, id_pc, id_rs_val, id_rt_val;
  logic [2:0]       id_br_type;
  logic             if_pred_taken, stall, id_valid, br_taken, mispredict;
  logic [31:0]      br_count, miss_count;
  modport master (
    output if_pc, stall, id_valid, id_pc, id_br_type, id_rs_val, id_rt_val,
    input  if_pred_taken, br_taken, mispredict, br_count, miss_count
  );
  modport slave (
    input  if_pc, stall, id_valid, id_pc, id_br_type, id_rs_val, id_rt_val,
    output if_pred_taken, br_taken, mispredict, br_count, miss_count
  );
endinterface

// File: rtl/branch_cond.sv
// branch_cond: combinational MIPS branch condition evaluator (signed, two's complement).
module branch_cond
  import branch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic [2:0]       type_i,
  output logic             cond_o
);
  logic eq, neg, zero;
  always_comb begin
    eq     = rs_i == rt_i;
    neg    = rs_i[WIDTH-1];
    zero   = rs_i == '0;
    cond_o = type_i == BT_BEQ  ? eq :
             type_i == BT_BNE  ? !eq :
             type_i == BT_BLEZ ? (neg | zero) :
             type_i == BT_BGTZ ? !(neg | zero) :
             type_i == BT_BLTZ ? neg :
             type_i == BT_BGEZ ? !neg : 1'b0;
  end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: ID-stage branch resolution with a 2-bit saturating-counter predictor
// and branch/mispredict event counters.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int         WIDTH     = 32,
  parameter int         PHT_DEPTH = 64,
  parameter logic [1:0] CNT_INIT  = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  branch_resolver_if.slave bus
);
  localparam int IDX = $clog2(PHT_DEPTH);
  logic [1:0]     pht_q [PHT_DEPTH];
  logic [1:0]     cnt_d;
  logic           pred_q, pred_d, cond, taken, resolving, miss;
  logic [31:0]    br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [IDX-1:0] if_idx, id_idx;
  logic           unused_pc;
  assign if_idx    = bus.if_pc[IDX+1:2];
  assign id_idx    = bus.id_pc[IDX+1:2];
  assign unused_pc = ^{bus.if_pc[WIDTH-1:IDX+2], bus.if_pc[1:0], bus.id_pc[WIDTH-1:IDX+2], bus.id_pc[1:0]};
  branch_cond #(.WIDTH(WIDTH)) u_cond (
    .rs_i   (bus.id_rs_val),
    .rt_i   (bus.id_rt_val),
    .type_i (bus.id_br_type),
    .cond_o (cond)
  );
  always_comb begin
    taken      = bus.id_valid & is_branch(bus.id_br_type) & cond;
    resolving  = bus.id_valid & is_branch(bus.id_br_type) & ~bus.stall;
    miss       = resolving & (taken != pred_q);
    pred_d     = miss ? 1'b0 : pht_q[if_idx][1];
    cnt_d      = sat_update(pht_q[id_idx], taken);
    br_cnt_d   = br_cnt_q + 32'd1;
    miss_cnt_d = miss_cnt_q + {31'd0, miss};
  end
  // IF reads the pre-edge entry, so a same-cycle ID update is seen one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= CNT_INIT;
      pred_q     <= 1'b0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else if (!bus.stall) begin
      pred_q <= pred_d;
      if (resolving) begin
        pht_q[id_idx] <= cnt_d;
        br_cnt_q      <= br_cnt_d;
        miss_cnt_q    <= miss_cnt_d;
      end
    end
  end
  assign bus.if_pred_taken = pht_q[if_idx][1];
  assign bus.br_taken      = taken;
  assign bus.mispredict    = miss;
  assign bus.br_count      = br_cnt_q;
  assign bus.miss_count    = miss_cnt_q;
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: randomized and directed checks of branch_resolver against a behavioural model.
module tb_branch_resolver;
  localparam int         WIDTH    = 32;
  localparam int         DEPTH    = 4;
  localparam logic [1:0] CNT_INIT = 2'b01;
  logic clk = 1'b0;
  logic reset = 1'b0;
  branch_resolver_if #(.WIDTH(WIDTH)) bus ();
  branch_resolver #(.WIDTH(WIDTH), .PHT_DEPTH(DEPTH), .CNT_INIT(CNT_INIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          pht_m [DEPTH];
  bit          pred_m;
  int unsigned br_m, miss_m;

  function automatic bit m_cond(int t, int rs, int rt);
    case (t)
      1: return rs == rt;
      2: return rs != rt;
      3: return rs <= 0;
      4: return rs > 0;
      5: return rs < 0;
      6: return rs >= 0;
      default: return 1'b0;
    endcase
  endfunction
  function automatic bit m_is_br(int t);
    return t >= 1 && t <= 6;
  endfunction
  function automatic int m_idx(logic [31:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction
  function automatic bit exp_pred(logic [31:0] pc);
    return pht_m[m_idx(pc)] >= 2;
  endfunction
  function automatic bit exp_taken();
    return bus.id_valid && m_is_br(int'(bus.id_br_type)) &&
           m_cond(int'(bus.id_br_type), int'(bus.id_rs_val), int'(bus.id_rt_val));
  endfunction
  function automatic bit exp_res();
    return bus.id_valid && m_is_br(int'(bus.id_br_type)) && !bus.stall;
  endfunction
  function automatic bit exp_miss();
    return exp_res() && (exp_taken() != pred_m);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) pht_m[i] = int'(CNT_INIT);
    pred_m = 1'b0;
    br_m   = 0;
    miss_m = 0;
  endtask
  task automatic drive(bit v, int t, logic [31:0] rs, logic [31:0] rt, logic [31:0] pc, logic [31:0] ifpc, bit st);
    bus.id_valid   = v;
    bus.id_br_type = 3'(t);
    bus.id_rs_val  = rs;
    bus.id_rt_val  = rt;
    bus.id_pc      = pc;
    bus.if_pc      = ifpc;
    bus.stall      = st;
  endtask
  task automatic tick();
    bit t, m, p, r;
    int ix;
    t  = exp_taken();
    m  = exp_miss();
    r  = exp_res();
    p  = exp_pred(bus.if_pc);
    ix = m_idx(bus.id_pc);
    @(posedge clk);
    if (!bus.stall) begin
      pred_m = m ? 1'b0 : p;
      if (r) begin
        pht_m[ix] = t ? (pht_m[ix] < 3 ? pht_m[ix] + 1 : 3) : (pht_m[ix] > 0 ? pht_m[ix] - 1 : 0);
        br_m++;
        if (m) miss_m++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 32'h3000, 32'h3000, 0);
    m_reset();
    #2;
    n_tests++; if (bus.if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred got %b want 0", bus.if_pred_taken); end
    n_tests++; if (bus.br_count !== 32'd0) begin n_fail++; $display("FAIL reset_br_count got %0d want 0", bus.br_count); end
    n_tests++; if (bus.miss_count !== 32'd0) begin n_fail++; $display("FAIL reset_miss_count got %0d want 0", bus.miss_count); end
    reset = 1'b0;
    tick();
    n_tests++; if (bus.if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL idle_pred got %b want 0", bus.if_pred_taken); end
    n_tests++; if (bus.br_count !== 32'd0) begin n_fail++; $display("FAIL idle_br_count got %0d want 0", bus.br_count); end
  endtask

  task automatic test_compare_kinds();
    int          kt   [9] = '{1, 2, 3, 4, 6, 5, 7, 0, 1};
    logic [31:0] krs  [9] = '{32'h5, 32'h5, 32'h80000000, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h5, 32'h5, 32'h5};
    logic [31:0] krt  [9] = '{32'h5, 32'h5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5, 32'h5, 32'h5};
    bit          kv   [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    bit          kexp [9] = '{1, 0, 1, 0, 1, 1, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      drive(kv[i], kt[i], krs[i], krt[i], 32'h3010, 32'h3010, 1);
      #2;
      n_tests++; if (bus.br_taken !== kexp[i]) begin n_fail++; $display("FAIL kind%0d_taken type=%0d got %b want %b", i, kt[i], bus.br_taken, kexp[i]); end
      n_tests++; if (bus.mispredict !== 1'b0) begin n_fail++; $display("FAIL kind%0d_stalled_miss got %b want 0", i, bus.mispredict); end
      tick();
    end
    n_tests++; if (bus.br_count !== 32'd0) begin n_fail++; $display("FAIL kinds_br_count got %0d want 0", bus.br_count); end
  endtask

  task automatic test_training();
    bit tk [11] = '{1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    bit vv [11] = '{1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    reset = 1'b1;
    #1;
    reset = 1'b0;
    m_reset();
    for (int i = 0; i < 11; i++) begin
      drive(vv[i], 1, 32'h7, tk[i] ? 32'h7 : 32'h8, 32'h3010, 32'h3010, 0);
      #2;
      n_tests++; if (bus.br_taken !== exp_taken()) begin n_fail++; $display("FAIL train%0d_taken got %b want %b", i, bus.br_taken, exp_taken()); end
      n_tests++; if (bus.mispredict !== exp_miss()) begin n_fail++; $display("FAIL train%0d_miss got %b want %b", i, bus.mispredict, exp_miss()); end
      n_tests++; if (bus.if_pred_taken !== exp_pred(bus.if_pc)) begin n_fail++; $display("FAIL train%0d_pred got %b want %b", i, bus.if_pred_taken, exp_pred(bus.if_pc)); end
      if (i == 0) begin
        n_tests++; if (bus.mispredict !== 1'b1) begin n_fail++; $display("FAIL train_first_miss got %b want 1", bus.mispredict); end
      end
      if (i == 2) begin
        n_tests++; if (bus.if_pred_taken !== 1'b1 || bus.mispredict !== 1'b0) begin n_fail++; $display("FAIL train_second got pred=%b miss=%b want pred=1 miss=0", bus.if_pred_taken, bus.mispredict); end
      end
      tick();
      n_tests++; if (dut.pht_q[0] !== 2'(pht_m[0])) begin n_fail++; $display("FAIL train%0d_entry got %b want %0d", i, dut.pht_q[0], pht_m[0]); end
      n_tests++; if (bus.miss_count !== miss_m) begin n_fail++; $display("FAIL train%0d_miss_count got %0d want %0d", i, bus.miss_count, miss_m); end
      if (i == 0) begin
        n_tests++; if (bus.miss_count !== 32'd1 || dut.pht_q[0] !== 2'b10) begin n_fail++; $display("FAIL train_first_state got miss=%0d entry=%b want 1 and 10", bus.miss_count, dut.pht_q[0]); end
      end
      if (i == 6) begin
        n_tests++; if (dut.pht_q[0] !== 2'b11) begin n_fail++; $display("FAIL train_saturate got %b want 11", dut.pht_q[0]); end
      end
    end
    n_tests++; if (dut.pht_q[0] !== 2'b00) begin n_fail++; $display("FAIL train_floor got %b want 00", dut.pht_q[0]); end
    n_tests++; if (bus.br_count !== 32'd10) begin n_fail++; $display("FAIL train_br_count got %0d want 10", bus.br_count); end
  endtask

  task automatic test_stall();
    int unsigned b0, m0;
    int          e0;
    bit          p0;
    drive(1, 2, 32'h1, 32'h2, 32'h3004, 32'h3004, 1);
    b0 = br_m; m0 = miss_m; e0 = pht_m[1]; p0 = pred_m;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_tests++; if (bus.mispredict !== exp_miss()) begin n_fail++; $display("FAIL stall%0d_miss got %b want %b", i, bus.mispredict, exp_miss()); end
      tick();
      n_tests++; if (bus.br_count !== b0 || bus.miss_count !== m0) begin n_fail++; $display("FAIL stall%0d_counts got %0d/%0d want %0d/%0d", i, bus.br_count, bus.miss_count, b0, m0); end
      n_tests++; if (dut.pht_q[1] !== 2'(e0) || dut.pred_q !== p0) begin n_fail++; $display("FAIL stall%0d_state got entry=%b pred=%b want %0d/%b", i, dut.pht_q[1], dut.pred_q, e0, p0); end
    end
    bus.stall = 1'b0;
    #2;
    n_tests++; if (bus.mispredict !== exp_miss()) begin n_fail++; $display("FAIL stall_release_miss got %b want %b", bus.mispredict, exp_miss()); end
    tick();
    n_tests++; if (bus.br_count !== b0 + 1) begin n_fail++; $display("FAIL stall_release_count got %0d want %0d", bus.br_count, b0 + 1); end
    n_tests++; if (dut.pht_q[1] !== 2'(pht_m[1])) begin n_fail++; $display("FAIL stall_release_entry got %b want %0d", dut.pht_q[1], pht_m[1]); end
    bus.id_valid = 1'b0;
    tick();
    n_tests++; if (bus.br_count !== b0 + 1) begin n_fail++; $display("FAIL stall_single_update got %0d want %0d", bus.br_count, b0 + 1); end
  endtask

  task automatic test_alias();
    bit old_p;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 32'h9, 32'h9, 32'h3010, 32'h3010, 0);
      old_p = exp_pred(32'h3010);
      #2;
      n_tests++; if (bus.if_pred_taken !== old_p) begin n_fail++; $display("FAIL alias%0d_same_cycle got %b want %b", i, bus.if_pred_taken, old_p); end
      tick();
      bus.id_valid = 1'b0;
      #1;
      n_tests++; if (bus.if_pred_taken !== exp_pred(32'h3010)) begin n_fail++; $display("FAIL alias%0d_next_cycle got %b want %b", i, bus.if_pred_taken, exp_pred(32'h3010)); end
    end
    bus.if_pc = 32'h3000;
    #1;
    n_tests++; if (bus.if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL alias_shared_index got %b want 1", bus.if_pred_taken); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] rs, rt;
    for (int i = 0; i < 200; i++) begin
      rt = $urandom;
      rs = $urandom;
      case ($urandom_range(0, 3))
        0: rs = 32'h0;
        1: rs = rt;
        default: ;
      endcase
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), rs, rt,
            32'h3000 + 4 * $urandom_range(0, 7), 32'h3000 + 4 * $urandom_range(0, 7), $urandom_range(0, 4) == 0);
      #2;
      n_tests++; if (bus.br_taken !== exp_taken()) begin n_fail++; $display("FAIL rand%0d_taken got %b want %b", i, bus.br_taken, exp_taken()); end
      n_tests++; if (bus.mispredict !== exp_miss()) begin n_fail++; $display("FAIL rand%0d_miss got %b want %b", i, bus.mispredict, exp_miss()); end
      n_tests++; if (bus.if_pred_taken !== exp_pred(bus.if_pc)) begin n_fail++; $display("FAIL rand%0d_pred got %b want %b", i, bus.if_pred_taken, exp_pred(bus.if_pc)); end
      tick();
      n_tests++; if (bus.br_count !== br_m || bus.miss_count !== miss_m) begin n_fail++; $display("FAIL rand%0d_counts got %0d/%0d want %0d/%0d", i, bus.br_count, bus.miss_count, br_m, miss_m); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 2, 32'h3, i[0] ? 32'h3 : 32'h4, 32'h3000 + 4 * i, 32'h3000, 0);
      tick();
    end
    n_tests++; if (bus.br_count !== br_m) begin n_fail++; $display("FAIL areset_pre_count got %0d want %0d", bus.br_count, br_m); end
    drive(1, 1, 32'h6, 32'h6, 32'h3008, 32'h3008, 0);
    #2;
    reset = 1'b1;
    m_reset();
    #1;
    n_tests++; if (bus.br_count !== 32'd0 || bus.miss_count !== 32'd0) begin n_fail++; $display("FAIL areset_counts got %0d/%0d want 0/0", bus.br_count, bus.miss_count); end
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++; if (dut.pht_q[i] !== CNT_INIT) begin n_fail++; $display("FAIL areset_entry%0d got %b want %b", i, dut.pht_q[i], CNT_INIT); end
    end
    n_tests++; if (bus.if_pred_taken !== CNT_INIT[1]) begin n_fail++; $display("FAIL areset_pred got %b want %b", bus.if_pred_taken, CNT_INIT[1]); end
    n_tests++; if (bus.mispredict !== 1'b1) begin n_fail++; $display("FAIL areset_comb_miss got %b want 1", bus.mispredict); end
    @(posedge clk);
    #1;
    n_tests++; if (bus.br_count !== 32'd0) begin n_fail++; $display("FAIL areset_held_count got %0d want 0", bus.br_count); end
    reset = 1'b0;
    #2;
    tick();
    n_tests++; if (bus.br_count !== 32'd1 || bus.miss_count !== 32'd1) begin n_fail++; $display("FAIL areset_resume got %0d/%0d want 1/1", bus.br_count, bus.miss_count); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_compare_kinds();
    test_training();
    test_stall();
    test_alias();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
